// File: rtl/comparator_rr_scheduler.sv
// comparator_rr_scheduler: one shared unsigned comparator for NUM_REQ requesters.
// Round-robin grant, one compare in flight, result returned over valid/ready.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake; req_ready is one-hot
//   req_a/req_b         packed operands, requester i at [i*N +: N]
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_r        owner id and {A>B, A==B, A<B}
//   busy                high while a compare is in CMP or RESP
//   cmp_count           completed response handshakes (wraps)
module comparator_rr_scheduler #(
  parameter int N       = 4,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [2:0]           rsp_r,
  output logic                 busy,
  output logic [CNT_W-1:0]     cmp_count
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_nx;
  logic [ID_W-1:0]  win;
  logic             found;
  logic [NUM_REQ-1:0] grant;
  logic [N-1:0]     a_q, b_q;
  logic [ID_W-1:0]  id_q;
  logic [2:0]       rsp_r_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [CNT_W-1:0] cnt;

  // Scan from the pointer upward, wrapping, and take the first valid.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && found)
      grant[win] = 1'b1;
  end

  assign ptr_nx = (win == ID_W'(NUM_REQ - 1)) ?
                  '0 : win + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = CMP;
      CMP:     state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      rsp_r_q  <= '0;
      rsp_id_q <= '0;
      cnt      <= '0;
    end else begin
      if (state == IDLE && found) begin
        a_q  <= req_a[win*N +: N];
        b_q  <= req_b[win*N +: N];
        id_q <= win;
        ptr  <= ptr_nx;
      end
      if (state == CMP) begin
        rsp_r_q  <= {a_q > b_q, a_q == b_q, a_q < b_q};
        rsp_id_q <= id_q;
      end
      if (state == RESP && rsp_ready)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_r     = rsp_r_q;
  assign rsp_id    = rsp_id_q;
  assign cmp_count = cnt;

endmodule

// File: tb/tb_comparator_rr_scheduler.sv
// tb_comparator_rr_scheduler: directed bench for the shared comparator.
// A second instance with a 4-bit counter shares the stimulus for wrap checks.
module tb_comparator_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready, req_ready4;
  logic        rsp_valid, rsp_valid4;
  logic        rsp_ready;
  logic [1:0]  rsp_id, rsp_id4;
  logic [2:0]  rsp_r, rsp_r4;
  logic        busy, busy4;
  logic [15:0] cmp_count;
  logic [3:0]  cmp_count4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  comparator_rr_scheduler #(.N(4), .NUM_REQ(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_r(rsp_r),
    .busy(busy), .cmp_count(cmp_count)
  );

  comparator_rr_scheduler #(.N(4), .NUM_REQ(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id4), .rsp_r(rsp_r4),
    .busy(busy4), .cmp_count(cmp_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i,
                        input logic [3:0] a,
                        input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Grant in IDLE, busy in CMP, response in RESP, idle again after.
  task automatic run_one(input int id, input logic [2:0] r);
    logic [3:0] g;
    g = 4'b0001 << id;
    chk("grant", req_ready, g);
    tick();
    chk("busy_cmp", busy, 1'b1);
    chk("no_rsp_cmp", rsp_valid, 1'b0);
    tick();
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_r", rsp_r, r);
    chk("ready_resp", req_ready, 4'b0000);
    tick();
    chk("rsp_done", rsp_valid, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // 1: reset
    tick();
    tick();
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_count", cmp_count, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_r", rsp_r, 3'b000);
    chk("rst_id", rsp_id, 2'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", req_ready, 4'b0001);
    req_valid = 4'b0000;
    #1;
    chk("none_ready", req_ready, 4'b0000);
    tick();
    chk("idle_busy", busy, 1'b0);

    // 2: single requester
    req_valid = 4'b0100;
    set_op(2, 4'd3, 4'd14);
    #1;
    chk("t2_grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    chk("t2_busy", busy, 1'b1);
    chk("t2_nov", rsp_valid, 1'b0);
    tick();
    chk("t2_valid", rsp_valid, 1'b1);
    chk("t2_id", rsp_id, 2'd2);
    chk("t2_r", rsp_r, 3'b001);
    tick();
    chk("t2_count", cmp_count, 16'd1);
    chk("t2_idle", rsp_valid, 1'b0);

    // 3: all valid, fresh pointer
    do_reset();
    set_op(0, 4'd8, 4'd8);
    set_op(1, 4'd11, 4'd9);
    set_op(2, 4'd15, 4'd7);
    set_op(3, 4'd6, 4'd1);
    req_valid = 4'b1111;
    #1;
    run_one(0, 3'b010);
    run_one(1, 3'b100);
    run_one(2, 3'b100);
    run_one(3, 3'b100);
    req_valid = 4'b0000;
    chk("t3_count", cmp_count, 16'd4);

    // 4: backpressure on req 1
    set_op(1, 4'd5, 4'd10);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("t4_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", rsp_valid, 1'b1);
      chk("t4_id", rsp_id, 2'd1);
      chk("t4_r", rsp_r, 3'b001);
      chk("t4_ready", req_ready, 4'b0000);
      chk("t4_count", cmp_count, 16'd4);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_hold", rsp_valid, 1'b1);
    tick();
    chk("t4_done", rsp_valid, 1'b0);
    chk("t4_count2", cmp_count, 16'd5);
    chk("t4_next", req_ready, 4'b0100);
    req_valid = 4'b0000;

    // 5: reset while in CMP
    set_op(2, 4'd4, 4'd2);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    chk("t5_cmp", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_nov", rsp_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_count", cmp_count, 16'd0);
    tick();
    chk("t5_nov2", rsp_valid, 1'b0);
    req_valid = 4'b1111;
    #1;
    chk("t5_grant", req_ready, 4'b0001);

    // 6: 17 back-to-back, counter wrap on 4-bit instance
    for (int i = 0; i < 4; i++)
      set_op(i, 4'd0, 4'd1);
    for (int i = 0; i < 17; i++)
      run_one(i % 4, 3'b001);
    req_valid = 4'b0000;
    chk("t6_cnt4", cmp_count4, 4'd1);
    chk("t6_cnt16", cmp_count, 16'd17);

    // 7: equality at the extremes, pointer now at 1
    set_op(1, 4'd15, 4'd15);
    req_valid = 4'b0010;
    #1;
    run_one(1, 3'b010);
    set_op(2, 4'd0, 4'd0);
    req_valid = 4'b0100;
    #1;
    run_one(2, 3'b010);
    req_valid = 4'b0000;
    chk("t7_count", cmp_count, 16'd19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
